// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared bus widths and arbiter state encoding for the wishbone arbiter slice
package wb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - saturating stall counter that flags the TIMEOUT-th consecutive stalled cycle
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt != MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the stalls before this cycle, so this stalled cycle is the TIMEOUT-th one
  assign hit = en && !clr && (cnt >= LAST);

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin wishbone classic arbiter with hung-transfer abort
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  arb_state_t state, state_nxt;
  logic       last_q, last_nxt;
  logic       wd_hit;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (s_ack_i),
    .en    (s_stb_o),
    .hit   (wd_hit)
  );

  // last_q = 1 means m1 was served last; it also names the owner while in ABORT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_q <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_q;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_nxt = OWN0;
        end else if (m1_cyc_i) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i || wd_hit) begin
          state_nxt = m0_cyc_i ? ABORT : IDLE;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i || wd_hit) begin
          state_nxt = m1_cyc_i ? ABORT : IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // stb is qualified by the owner's cyc so a release with stb still high never reaches the slave
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    timeout_o = 1'b0;
    case (state)
      OWN0: begin
        s_cyc_o   = 1'b1;
        s_stb_o   = m0_stb_i & m0_cyc_i;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        m0_ack_o  = s_ack_i & m0_stb_i;
        m0_data_o = s_data_i;
      end
      OWN1: begin
        s_cyc_o   = 1'b1;
        s_stb_o   = m1_stb_i & m1_cyc_i;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        m1_ack_o  = s_ack_i & m1_stb_i;
        m1_data_o = s_data_i;
      end
      ABORT: begin
        timeout_o = 1'b1;
        m0_err_o  = ~last_q;
        m1_err_o  = last_q;
      end
      default: ;
    endcase
  end

  assign gnt_o = {state == OWN1, state == OWN0};

endmodule
